// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side adapter for the single-clock banked FIFO. It issues fifo_rd_en
//   and captures fifo_dout one cycle later into a 2-entry head/tail buffer. The
//   data is presented as a first-word-fall-through valid/ready stream at up to
//   one beat per cycle.
//
//   Optional feature macro: FIFO_RD_BEAT_CNT_EN. When it is defined, the
//   beat_cnt port and its counter are present.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of buffer and in-flight read
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data, valid the cycle after an accepted fifo_rd_en
//   fifo_rd_en   read request to the FIFO
//   m_valid      stream valid (buffer non-empty)
//   m_ready      stream consumer ready
//   m_data       stream data, head of the buffer
//   buf_cnt      buffer occupancy 0..2
//   beat_cnt     accepted-beat count, wraps (FIFO_RD_BEAT_CNT_EN only)
//
// state   | meaning
// S_EMPTY | buffer holds no word
// S_ONE   | head holds the next word
// S_TWO   | head and tail both hold words, head is older
module fifo_stream_reader #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [1:0]       buf_cnt
`ifdef FIFO_RD_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   head_q, head_d;
  logic [DW-1:0]   tail_q, tail_d;
  logic            rd_pend_q, rd_pend_d;
  logic            pop;
  logic [2:0]      occ_after;

  assign m_valid = (state_q != S_EMPTY);
  assign m_data  = head_q;
  assign buf_cnt = state_q;

  // A new read is allowed only if, after this cycle's pop, the buffer plus the
  // word already in flight leaves room for one more word. This keeps
  // buf_cnt + rd_pend <= 2, so an arrival can never meet a full buffer.
  always_comb begin
    pop        = m_valid & m_ready;
    occ_after  = {1'b0, buf_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
    fifo_rd_en = ~flush & ~fifo_empty & (occ_after <= 3'd1);
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rd_pend_d = fifo_rd_en;
    if (flush) begin
      // The word still in flight is dropped because rd_pend clears with it.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (rd_pend_q) begin
            head_d  = fifo_dout;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          case ({rd_pend_q, pop})
            2'b10: begin
              tail_d  = fifo_dout;
              state_d = S_TWO;
            end
            2'b01: state_d = S_EMPTY;
            2'b11: head_d = fifo_dout;
            default: ;
          endcase
        end
        S_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      rd_pend_q <= rd_pend_d;
    end
  end

`ifdef FIFO_RD_BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Counts every consumed beat, including one popped in a flush cycle.
  always_comb begin
    beat_cnt_d = beat_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a FIFO environment plus a queue-level
// model of the stream buffer.
module tb_fifo_stream_reader;
  localparam int DW    = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [DW-1:0]    fifo_dout = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic [1:0]       buf_cnt;
`ifdef FIFO_RD_BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_cnt    (buf_cnt)
`ifdef FIFO_RD_BEAT_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] fq[$];     // words still held by the FIFO
  logic [DW-1:0] mq[$];     // words the adapter should be buffering
  bit            pend = 1'b0;
  logic [DW-1:0] inflight = '0;
  int            beats = 0;
  int            rd_pulses = 0;
  int            dut_pops = 0;
  logic [DW-1:0] next_word = 16'h0001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 16'h0001;
    end
  endtask

  task automatic cycle(input logic rdy, input logic fl);
    int   pop_m;
    int   occ;
    logic dut_rd;
    @(negedge clk);
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (fq.size() == 0);
    #1;
    pop_m = (mq.size() != 0 && rdy) ? 1 : 0;
    occ   = mq.size() + int'(pend) - pop_m;
    check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
    check("buf_cnt", 32'(buf_cnt), 32'(mq.size()));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(!fl && fq.size() != 0 && occ <= 1));
`ifdef FIFO_RD_BEAT_CNT_EN
    check("beat_cnt", 32'(beat_cnt), 32'(beats % (1 << CNT_W)));
`endif
    dut_rd = fifo_rd_en;
    if (dut_rd) rd_pulses++;
    if (m_valid && rdy) dut_pops++;
    @(posedge clk);
    #1;
    beats += pop_m;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_m != 0) void'(mq.pop_front());
      if (pend) mq.push_back(inflight);
    end
    if (dut_rd && fq.size() != 0) begin
      inflight  = fq.pop_front();
      fifo_dout = inflight;
      pend      = 1'b1;
    end else begin
      pend      = 1'b0;
      fifo_dout = DW'($urandom);
    end
  endtask

  // Asserted just after a posedge; released two edges later, before the next
  // negedge, so the first cycle() after it is the first cycle out of reset.
  task automatic do_reset();
    rst_n      = 1'b0;
    flush      = 1'b0;
    fifo_empty = (fq.size() == 0);
    mq.delete();
    pend       = 1'b0;
    beats      = 0;
    fifo_dout  = DW'($urandom);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_buf_cnt", 32'(buf_cnt), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'(fq.size() != 0));
`ifdef FIFO_RD_BEAT_CNT_EN
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a non-empty FIFO, then stream 8 words at full rate.
    load(8);
    @(posedge clk);
    #1;
    do_reset();
    dut_pops = 0;
    repeat (12) cycle(1'b1, 1'b0);
    check("stream_beats", 32'(dut_pops), 32'd8);

    // Backpressure: exactly two reads, then a gapless drain.
    load(5);
    rd_pulses = 0;
    repeat (10) cycle(1'b0, 1'b0);
    check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
    check("bp_buf_cnt", 32'(buf_cnt), 32'd2);
    dut_pops = 0;
    repeat (5) cycle(1'b1, 1'b0);
    check("bp_drain_beats", 32'(dut_pops), 32'd5);
    repeat (4) cycle(1'b1, 1'b0);

    // Alternating ready.
    load(8);
    for (int i = 0; i < 24; i++) cycle((i % 2) == 0, 1'b0);

    // Flush in steady state (one buffered, one in flight).
    load(8);
    repeat (4) cycle(1'b1, 1'b0);
    check("pre_flush_buf", 32'(buf_cnt), 32'd1);
    cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b0);

    // Reset in the middle of a transfer.
    load(8);
    repeat (5) cycle(1'b1, 1'b0);
    do_reset();
    repeat (12) cycle(1'b1, 1'b0);

    // 17 pops from reset wraps a 4-bit counter to 1; flush leaves it alone.
    fq.delete();
    do_reset();
    load(17);
    repeat (21) cycle(1'b1, 1'b0);
`ifdef FIFO_RD_BEAT_CNT_EN
    check("beat_wrap", 32'(beat_cnt), 32'd1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("beat_after_flush", 32'(beat_cnt), 32'd1);
`endif

    // Random traffic, readiness and flushes.
    repeat (1500) begin
      if (fq.size() < 12 && $urandom_range(0, 2) != 0) load($urandom_range(1, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
